// File: rtl/stream_ingress_fifo_if.sv
// Stream ingress FIFO port bundle: producer side, consumer side and status.
// master drives the stream and consumer controls; slave is the FIFO.
interface stream_ingress_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic [DATA_W-1:0] stream_data;
  logic              stream_valid;
  logic              flush;
  logic              clear_err;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   level;
  logic              busy;
  logic              error;
  logic              watchdog_rst;

  modport master (
    output stream_data, stream_valid,
    output flush, clear_err, out_ready,
    input  out_data, out_valid, level,
    input  busy, error, watchdog_rst
  );

  modport slave (
    input  stream_data, stream_valid,
    input  flush, clear_err, out_ready,
    output out_data, out_valid, level,
    output busy, error, watchdog_rst
  );
endinterface

// File: rtl/stream_ingress_fifo.sv
// Elementary-stream input buffer: show-ahead FIFO with hysteretic busy,
// sticky overflow error, synchronous flush and a consumer stall watchdog.
module stream_ingress_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int BUSY_HI   = 48,
  parameter int BUSY_LO   = 16,
  parameter int WDT_W     = 24,
  parameter int WDT_LIMIT = 1000000
) (
  input logic               clk,
  input logic               rst,
  stream_ingress_fifo_if.slave s
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LW    = ADDR_W + 1;
  localparam logic [ADDR_W:0] HI = LW'(BUSY_HI);
  localparam logic [ADDR_W:0] LO = LW'(BUSY_LO);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_d;
  logic              busy_q;
  logic              busy_d;
  logic              err_q;
  logic              full;
  logic              do_wr;
  logic              do_pop;
  logic              ovf;
  logic              stall;

  // level never exceeds DEPTH, so its MSB alone marks full
  assign full   = level_q[ADDR_W];
  assign do_pop = s.out_valid & s.out_ready;
  assign do_wr  = s.stream_valid & (~full | do_pop);
  assign ovf    = s.stream_valid & full & ~do_pop;
  assign stall  = s.out_valid & ~s.out_ready;

  assign s.out_valid = |level_q;
  assign s.out_data  = mem[rd_ptr];
  assign s.level     = level_q;
  assign s.busy      = busy_q;
  assign s.error     = err_q;

  always_comb begin
    level_d = level_q;
    busy_d  = busy_q;
    if (s.flush) begin
      level_d = '0;
    end else if (do_wr & ~do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop & ~do_wr) begin
      level_d = level_q - LW'(1);
    end
    if (level_d >= HI) begin
      busy_d = 1'b1;
    end else if (level_d <= LO) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !s.flush) begin
      mem[wr_ptr] <= s.stream_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      busy_q  <= busy_d;
      if (s.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (do_pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // overflow beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (ovf) begin
      err_q <= 1'b1;
    end else if (s.clear_err) begin
      err_q <= 1'b0;
    end
  end

  generate
    if (WDT_LIMIT == 0) begin : g_no_wdt
      assign s.watchdog_rst = 1'b0;
    end else begin : g_wdt
      localparam logic [WDT_W-1:0] LAST = WDT_W'(WDT_LIMIT - 1);
      logic [WDT_W-1:0] wcnt;
      logic             wdt_q;

      assign s.watchdog_rst = wdt_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wcnt  <= '0;
          wdt_q <= 1'b0;
        end else if (s.flush || !stall) begin
          wcnt  <= '0;
          wdt_q <= 1'b0;
        end else if (wcnt == LAST) begin
          wcnt  <= '0;
          wdt_q <= 1'b1;
        end else begin
          wcnt  <= wcnt + WDT_W'(1);
          wdt_q <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_stream_ingress_fifo.sv
// Bench for stream_ingress_fifo: directed phases plus random traffic,
// every cycle checked against a queue-based reference model.
module tb_stream_ingress_fifo;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int LIM   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  stream_ingress_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) io ();

  stream_ingress_fifo #(
    .DATA_W(DW), .ADDR_W(AW),
    .BUSY_HI(48), .BUSY_LO(16),
    .WDT_W(24), .WDT_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(io)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q[$];
  bit m_busy;
  bit m_err;
  bit m_wdt;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(io.out_valid), 32'(q.size() != 0));
    chk("level", 32'(io.level), 32'(q.size()));
    if (q.size() != 0) chk("out_data", 32'(io.out_data), 32'(q[0]));
    chk("busy", 32'(io.busy), 32'(m_busy));
    chk("error", 32'(io.error), 32'(m_err));
    chk("watchdog_rst", 32'(io.watchdog_rst), 32'(m_wdt));
  endtask

  task automatic model_clear();
    q.delete();
    m_busy = 0;
    m_err  = 0;
    m_wdt  = 0;
    m_cnt  = 0;
  endtask

  task automatic step(input bit sv, input logic [DW-1:0] d, input bit rdy,
                      input bit fl, input bit ce);
    int n;
    bit pop;
    bit wr;
    bit ovf;
    bit stall;
    io.stream_valid = sv;
    io.stream_data  = d;
    io.out_ready    = rdy;
    io.flush        = fl;
    io.clear_err    = ce;
    n     = q.size();
    pop   = (n > 0) && rdy;
    wr    = sv && ((n < DEPTH) || pop);
    ovf   = sv && (n == DEPTH) && !pop;
    stall = (n > 0) && !rdy;
    if (fl) begin
      q.delete();
      m_busy = 0;
      m_cnt  = 0;
      m_wdt  = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (wr) q.push_back(d);
      if (q.size() >= 48) m_busy = 1;
      else if (q.size() <= 16) m_busy = 0;
      if (stall) begin
        if (m_cnt == LIM - 1) begin
          m_cnt = 0;
          m_wdt = 1;
        end else begin
          m_cnt++;
          m_wdt = 0;
        end
      end else begin
        m_cnt = 0;
        m_wdt = 0;
      end
    end
    if (ovf) m_err = 1;
    else if (ce) m_err = 0;
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int pulses;
    io.stream_valid = 0;
    io.stream_data  = '0;
    io.out_ready    = 0;
    io.flush        = 0;
    io.clear_err    = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(io.out_valid), 0);
    chk("rst_level", 32'(io.level), 0);
    chk("rst_busy", 32'(io.busy), 0);
    chk("rst_error", 32'(io.error), 0);
    chk("rst_wdt", 32'(io.watchdog_rst), 0);
    rst = 1'b1;

    // three writes then drain in order
    step(1, 8'h47, 0, 0, 0);
    chk("first_valid", 32'(io.out_valid), 1);
    chk("first_data", 32'(io.out_data), 32'h47);
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h01, 0, 0, 0);
    chk("lvl3", 32'(io.level), 3);
    step(0, 8'h00, 1, 0, 0);
    chk("drain1", 32'(io.out_data), 32'h00);
    step(0, 8'h00, 1, 0, 0);
    chk("drain2", 32'(io.out_data), 32'h01);
    step(0, 8'h00, 1, 0, 0);
    chk("drained_valid", 32'(io.out_valid), 0);
    chk("drained_level", 32'(io.level), 0);

    // overflow and sticky error
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
    chk("full_lvl", 32'(io.level), 64);
    step(1, 8'hAA, 0, 0, 0);
    chk("ovf_err", 32'(io.error), 1);
    chk("ovf_lvl", 32'(io.level), 64);
    step(0, 8'h00, 0, 0, 1);
    chk("clr_err", 32'(io.error), 0);
    step(1, 8'hAB, 0, 0, 1);
    chk("ovf_clr_err", 32'(io.error), 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 1);

    // busy hysteresis
    for (int i = 0; i < 47; i++) step(1, 8'($urandom), 0, 0, 0);
    chk("busy47", 32'(io.busy), 0);
    step(1, 8'($urandom), 0, 0, 0);
    chk("busy48", 32'(io.busy), 1);
    for (int i = 0; i < 31; i++) step(0, 8'h00, 1, 0, 0);
    chk("busy17", 32'(io.busy), 1);
    step(0, 8'h00, 1, 0, 0);
    chk("busy16", 32'(io.busy), 0);

    // full pass-through with wrapping pointers
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      step(1, 8'($urandom), 1, 0, 0);
      chk("pass_lvl", 32'(io.level), 64);
      chk("pass_err", 32'(io.error), 0);
    end

    // watchdog: held stall pulses at 10 and 20
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'h5A, 0, 0, 0);
    pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      step(0, 8'h00, 0, 0, 0);
      chk("wdt_stall", 32'(io.watchdog_rst), 32'((k == 10) || (k == 20)));
      if (io.watchdog_rst === 1'b1) pulses++;
    end
    chk("wdt_pulses", 32'(pulses), 2);
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'h5B, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 8'h00, 1, 0, 0);
      chk("wdt_none", 32'(io.watchdog_rst), 0);
    end

    // flush beats a same-cycle write
    for (int i = 0; i < 30; i++) step(1, 8'($urandom), 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0);
    chk("flush_lvl", 32'(io.level), 0);
    chk("flush_valid", 32'(io.out_valid), 0);
    chk("flush_busy", 32'(io.busy), 0);
    step(0, 8'h00, 0, 0, 0);
    chk("flush_discard", 32'(io.level), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
           ($urandom % 60) == 0, ($urandom % 20) == 0);
    end
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 2) != 0, 8'($urandom), ($urandom % 4) == 0,
           ($urandom % 90) == 0, ($urandom % 30) == 0);
    end

    // asynchronous reset mid-stream
    step(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 8'($urandom), 0, 0, 0);
    chk("pre_rst_busy", 32'(io.busy), 1);
    chk("pre_rst_err", 32'(io.error), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(io.out_valid), 0);
    chk("arst_level", 32'(io.level), 0);
    chk("arst_busy", 32'(io.busy), 0);
    chk("arst_error", 32'(io.error), 0);
    chk("arst_wdt", 32'(io.watchdog_rst), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 8'h3C, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
